// File: rtl/freq_counter_pkg.sv
// freq_counter_pkg: constants and types shared between the frequency counter
// and its period configuration loader.
//   CNT_BITS           - width of the period word
//   CNT_DEFAULT_PERIOD - period used after reset (clk cycles per window)
//   CNT_MIN_PERIOD     - smallest period the loader accepts
//   loader_state_e     - loader FSM states
//   frame_len()        - serial frame length for a given period width
// Optional feature macro: PERIOD_CONFIG_PARITY_EN (adds an even-parity bit
// to every serial frame).
package freq_counter_pkg;

   localparam int CNT_BITS           = 12;
   localparam int CNT_DEFAULT_PERIOD = 1200;
   localparam int CNT_MIN_PERIOD     = 16;

`ifdef PERIOD_CONFIG_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2,
      ST_LOAD  = 2'd3
   } loader_state_e;

   function automatic int frame_len(input int bits);
      return bits + PARITY_BITS;
   endfunction

endpackage

// File: rtl/period_config_loader_if.sv
// period_config_loader_if: pin side serial link plus the parallel period bus.
//   cfg_sclk / cfg_sdata / cfg_latch_n - asynchronous serial pins
//   period / period_load               - accepted period and its load strobe
//   busy / err                         - frame in progress / rejected frame
// Modports: master drives the pins and observes the bus (board / bench),
// slave is the loader itself.
interface period_config_loader_if #(
   parameter int BITS = freq_counter_pkg::CNT_BITS
);
   logic            cfg_sclk;
   logic            cfg_sdata;
   logic            cfg_latch_n;
   logic [BITS-1:0] period;
   logic            period_load;
   logic            busy;
   logic            err;

   modport master (
      output cfg_sclk, cfg_sdata, cfg_latch_n,
      input  period, period_load, busy, err
   );

   modport slave (
      input  cfg_sclk, cfg_sdata, cfg_latch_n,
      output period, period_load, busy, err
   );
endinterface

// File: rtl/period_config_loader_sync_edge.sv
// sync_edge: 2-flop synchroniser for an asynchronous pin plus a delay flop
// for edge detection.
//   clk, reset_n - clock and asynchronous active-low reset
//   async_in     - raw pin
//   level        - synchronised level
//   rise / fall  - single-cycle pulses on synchronised edges
// RST_VAL is the pin's idle level, so leaving reset with an idle pin never
// produces a spurious edge.
module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [2:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], async_in};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= {3{RST_VAL}};
      else          sync_q <= sync_d;
   end

   assign level = sync_q[1];
   assign rise  =  sync_q[1] & ~sync_q[2];
   assign fall  = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/period_config_loader.sv
// period_config_loader: receives a new counting period over a 3-wire serial
// link (sclk / sdata MSB first / latch_n framing), validates the frame and
// presents it on a parallel period bus with a one-cycle period_load strobe.
//   clk, reset_n - system clock, asynchronous active-low reset
//   bus (slave)  - cfg_* pins in; period, period_load, busy, err out
// Parameters: BITS (period width), RESET_PERIOD, MIN_PERIOD.
// Optional feature macro: PERIOD_CONFIG_PARITY_EN - frame carries a trailing
// even-parity bit that is checked before acceptance.
module period_config_loader
   import freq_counter_pkg::*;
#(
   parameter int BITS         = CNT_BITS,
   parameter int RESET_PERIOD = CNT_DEFAULT_PERIOD,
   parameter int MIN_PERIOD   = CNT_MIN_PERIOD
) (
   input  logic                  clk,
   input  logic                  reset_n,
   period_config_loader_if.slave bus
);

   localparam int FRAME_LEN = frame_len(BITS);
   localparam int CNT_W     = $clog2(FRAME_LEN + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);

   // ---------------- input conditioning ----------------
   logic sclk_rise, sdata_lvl, latch_rise, latch_fall;
   logic sclk_lvl, sclk_fall, sdata_rise, sdata_fall, latch_lvl;

   sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .reset_n(reset_n), .async_in(bus.cfg_sclk),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
   );

   sync_edge #(.RST_VAL(1'b0)) u_sync_sdata (
      .clk(clk), .reset_n(reset_n), .async_in(bus.cfg_sdata),
      .level(sdata_lvl), .rise(sdata_rise), .fall(sdata_fall)
   );

   sync_edge #(.RST_VAL(1'b1)) u_sync_latch (
      .clk(clk), .reset_n(reset_n), .async_in(bus.cfg_latch_n),
      .level(latch_lvl), .rise(latch_rise), .fall(latch_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{sclk_lvl, sclk_fall, sdata_rise, sdata_fall, latch_lvl};

   // ---------------- state ----------------
   loader_state_e          state_q, state_d;
   logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]       cnt_q,   cnt_d;
   logic [BITS-1:0]        period_q, period_d;

   logic [BITS-1:0] data_word;
   logic            parity_ok;
   logic            frame_ok;

`ifdef PERIOD_CONFIG_PARITY_EN
   // Data bits precede the parity bit, which lands in the LSB.
   assign data_word = shreg_q[FRAME_LEN-1:1];
   assign parity_ok = ~(^shreg_q);
`else
   assign data_word = shreg_q;
   assign parity_ok = 1'b1;
`endif

   // A saturated count (over-length frame) never equals CNT_FULL, so it is
   // rejected here even though the register holds a plausible word.
   assign frame_ok = (cnt_q == CNT_FULL) && (data_word >= BITS'(MIN_PERIOD)) && parity_ok;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      case (state_q)
         ST_IDLE: begin
            if (latch_fall) begin
               shreg_d = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // Latch rise wins over a coincident sclk rise; that bit is dropped.
            if (latch_rise) begin
               state_d = ST_CHECK;
            end else if (sclk_rise) begin
               shreg_d = {shreg_q[FRAME_LEN-2:0], sdata_lvl};
               if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
            end
         end
         ST_CHECK: begin
            // period is captured on the way into LOAD so it is already valid
            // in the cycle that period_load is high.
            if (frame_ok) begin
               period_d = data_word;
               state_d  = ST_LOAD;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_LOAD: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         period_q <= BITS'(RESET_PERIOD);
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
      end
   end

   // ---------------- outputs ----------------
   assign bus.period      = period_q;
   assign bus.period_load = (state_q == ST_LOAD);
   assign bus.err         = (state_q == ST_CHECK) && !frame_ok;
   assign bus.busy        = (state_q == ST_SHIFT) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_period_config_loader.sv
// tb_period_config_loader: directed, table-driven bench for
// period_config_loader. Works for both builds (PERIOD_CONFIG_PARITY_EN
// defined or not); the vector table follows the frame format of the build.
module tb_period_config_loader;
   import freq_counter_pkg::*;

   localparam int BITS = CNT_BITS;

   logic clk;
   logic reset_n;

   period_config_loader_if #(.BITS(BITS)) bus ();

   period_config_loader #(
      .BITS(BITS), .RESET_PERIOD(1200), .MIN_PERIOD(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event monitor sampled on the falling edge, away from the active edge.
   int load_cnt = 0;
   int err_cnt  = 0;
   int load_period = 0;
   always @(negedge clk) begin
      if (bus.period_load) begin
         load_cnt    <= load_cnt + 1;
         load_period <= int'(bus.period);
      end
      if (bus.err) err_cnt <= err_cnt + 1;
   end

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // sclk at clk/8: 4 cycles low with data set up, 4 cycles high.
   task automatic shift_bits(input logic [15:0] bits, input int msb, input int lsb);
      for (int i = msb; i >= lsb; i--) begin
         bus.cfg_sdata = bits[i];
         bus.cfg_sclk  = 1'b0;
         cyc(4);
         bus.cfg_sclk  = 1'b1;
         cyc(4);
      end
      bus.cfg_sclk = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] bits, input int n);
      bus.cfg_latch_n = 1'b0;
      cyc(4);
      shift_bits(bits, n - 1, 0);
      cyc(4);
      bus.cfg_latch_n = 1'b1;
   endtask

   typedef struct {
      logic [15:0] bits;
      int          n;
      int          exp_load;
      int          exp_err;
      int          exp_period;
   } vec_t;

   vec_t vecs[7];

   int l0, e0;

   initial begin
`ifdef PERIOD_CONFIG_PARITY_EN
      vecs[0] = '{16'h0258, 12, 0, 1, 1200}; // missing parity bit: too short
      vecs[1] = '{16'h04B1, 13, 0, 1, 1200}; // 0x258 with wrong parity
      vecs[2] = '{16'h0011, 13, 0, 1, 1200}; // 8 < MIN_PERIOD, parity ok
      vecs[3] = '{16'h0021, 13, 1, 0, 16};   // 16 == MIN_PERIOD
      vecs[4] = '{16'h04B0, 13, 1, 0, 600};  // 0x258, parity 0
      vecs[5] = '{16'h1FFE, 13, 1, 0, 4095}; // all ones, parity 0
      vecs[6] = '{16'h12C0, 14, 0, 1, 4095}; // over-length
`else
      vecs[0] = '{16'h00FF, 11, 0, 1, 1200}; // too short
      vecs[1] = '{16'h1258, 13, 0, 1, 1200}; // too long
      vecs[2] = '{16'h0008, 12, 0, 1, 1200}; // 8 < MIN_PERIOD
      vecs[3] = '{16'h000F, 12, 0, 1, 1200}; // 15, just below minimum
      vecs[4] = '{16'h0010, 12, 1, 0, 16};   // minimum accepted
      vecs[5] = '{16'h0258, 12, 1, 0, 600};
      vecs[6] = '{16'h0FFF, 12, 1, 0, 4095}; // maximum
`endif

      reset_n         = 1'b0;
      bus.cfg_sclk    = 1'b0;
      bus.cfg_sdata   = 1'b0;
      bus.cfg_latch_n = 1'b1;
      cyc(3);
      chk("rst_period", int'(bus.period), 1200);
      reset_n = 1'b1;

      // Idle pins after reset: outputs hold their reset values.
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle_period", int'(bus.period), 1200);
         chk("idle_load", int'(bus.period_load), 0);
         chk("idle_err", int'(bus.err), 0);
         chk("idle_busy", int'(bus.busy), 0);
      end
      cyc(1);

      // Table-driven frames.
      for (int v = 0; v < 7; v++) begin
         l0 = load_cnt;
         e0 = err_cnt;
         send_frame(vecs[v].bits, vecs[v].n);
         cyc(12);
         chk($sformatf("v%0d_load", v), load_cnt - l0, vecs[v].exp_load);
         chk($sformatf("v%0d_err", v), err_cnt - e0, vecs[v].exp_err);
         chk($sformatf("v%0d_period", v), int'(bus.period), vecs[v].exp_period);
         chk($sformatf("v%0d_busy", v), int'(bus.busy), 0);
         if (vecs[v].exp_load != 0)
            chk($sformatf("v%0d_load_period", v), load_period, vecs[v].exp_period);
      end

      // Back-to-back frames with the minimum 4-cycle latch_n high gap.
      l0 = load_cnt;
      e0 = err_cnt;
`ifdef PERIOD_CONFIG_PARITY_EN
      send_frame(16'h04B0, 13);
      cyc(4);
      send_frame(16'h0960, 13);
`else
      send_frame(16'h0258, 12);
      cyc(4);
      send_frame(16'h04B0, 12);
`endif
      cyc(12);
      chk("b2b_loads", load_cnt - l0, 2);
      chk("b2b_err", err_cnt - e0, 0);
      chk("b2b_load_period", load_period, 1200);
      chk("b2b_period", int'(bus.period), 1200);

      // Make period differ from the reset value before the mid-frame reset.
      send_frame(16'h0258 << (CNT_BITS == BITS ? PARITY_BITS : 0), 12 + PARITY_BITS);
      cyc(12);
      chk("pre_rst_period", int'(bus.period), 600);

      // Reset after 6 of 12 bits; rest of the frame arrives under reset.
      l0 = load_cnt;
      e0 = err_cnt;
      bus.cfg_latch_n = 1'b0;
      cyc(4);
      shift_bits(16'h0258, 11, 6);
      chk("mid_busy_before", int'(bus.busy), 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_period", int'(bus.period), 1200);
      chk("mid_rst_busy", int'(bus.busy), 0);
      chk("mid_rst_load", int'(bus.period_load), 0);
      chk("mid_rst_err", int'(bus.err), 0);
      shift_bits(16'h0258, 5, 0);
      cyc(4);
      bus.cfg_latch_n = 1'b1;
      cyc(12);
      reset_n = 1'b1;
      cyc(20);
      chk("mid_no_load", load_cnt - l0, 0);
      chk("mid_no_err", err_cnt - e0, 0);
      chk("mid_period", int'(bus.period), 1200);

      // Loader recovers normally after the interrupted frame.
      l0 = load_cnt;
      send_frame(16'h0010 << PARITY_BITS | 16'(PARITY_BITS), 12 + PARITY_BITS);
      cyc(12);
      chk("recover_load", load_cnt - l0, 1);
      chk("recover_period", int'(bus.period), 16);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/period_config_loader.md
Name: period_config_loader

Overview:
- Upstream configuration stage for the frequency counter.
- Receives a new counting period over a 3-wire serial link from external pins, then validates the frame.
- Presents the result on a parallel period bus with a one-cycle period_load strobe, which the counter samples to replace its update period.
- Lets the gate time be retuned without re-synthesis.

Parameters:
- BITS, 12, width of the period word; matches the counter's period width.
- RESET_PERIOD, 1200, value driven on period after reset (clk cycles per counting window).
- MIN_PERIOD, 16, smallest accepted period; smaller values are rejected.

Ports:
- clk  input  1  system clock (12 MHz)
- reset_n  input  1  asynchronous active-low reset
- cfg_sclk  input  1  serial clock from pin, asynchronous; data sampled on its rising edge
- cfg_sdata  input  1  serial data from pin, asynchronous; MSB first
- cfg_latch_n  input  1  frame enable from pin, asynchronous; low = frame in progress
- period  output  BITS  current accepted period; stable between loads
- period_load  output  1  one-cycle strobe; period is valid in the same cycle
- busy  output  1  high while a frame is being received or checked
- err  output  1  one-cycle strobe on a rejected frame

Behaviour:
- Reset is asynchronous, active-low, and may occur at any time, including mid-frame.
  - period = RESET_PERIOD; period_load = 0; busy = 0; err = 0.
  - State = IDLE; shift register and bit count cleared.
  - Synchroniser flops clear to the idle pin levels: sclk = 0, latch_n = 1.
  - A partial frame interrupted by reset is discarded.
- Input conditioning:
  - Each pin passes through a 2-flop synchroniser plus a third flop for edge detection.
  - Edge detects are single-cycle pulses on synchronised levels.
  - cfg_sclk must be at most clk/4 with high and low phases of at least 2 clk cycles; faster input is undefined.
- States: IDLE, SHIFT, CHECK, LOAD.
  - IDLE:
    - A synchronised latch_n falling edge clears the shift register and bit count, then moves to SHIFT.
    - sclk edges in IDLE are ignored.
  - SHIFT:
    - Each synchronised sclk rising edge shifts the synchronised sdata into the LSB, so the register shifts left.
    - Bit count increments and saturates at FRAME_LEN+1.
    - A synchronised latch_n rising edge moves to CHECK.
    - If an sclk rise and a latch rise are detected in the same cycle, latch wins and that sclk edge is dropped.
  - CHECK: one cycle. The frame is accepted only if all hold:
    - bit count == FRAME_LEN (FRAME_LEN = BITS, or BITS+1 with the optional feature);
    - data word >= MIN_PERIOD;
    - optional parity check passes.
    - Accepted: go to LOAD. Rejected: err = 1 for this one cycle, period unchanged, go to IDLE.
  - LOAD:
    - period is registered from the data word and period_load = 1 for exactly one cycle.
    - Return to IDLE.
- busy = 1 in SHIFT and CHECK; 0 in IDLE and LOAD.
- Latency:
  - The synchronised latch rising edge is detected 3 clk cycles after the pin edge, with ±1 cycle of synchroniser phase.
  - period_load follows 2 cycles after that detection.
- Over-length frames (bit count > FRAME_LEN): rejected. The shift register holds the last BITS (or BITS+1) bits, but the saturated count forces the rejection.
- A new latch_n fall while in CHECK or LOAD is missed. The sender must keep latch_n high for at least 4 clk cycles between frames.
- period is never modified except by reset or LOAD.

Optional Feature:
- Macro: PERIOD_CONFIG_PARITY_EN.
- Defined:
  - Frame is BITS data bits followed by 1 even-parity bit, i.e. the XOR of all BITS+1 bits is 0.
  - A parity mismatch in CHECK rejects the frame with err.
- Undefined:
  - Frame is BITS data bits only with no parity check.
  - The err port still exists and flags length and minimum-period violations only.

Decomposition:
- Shared package freq_counter_pkg holds:
  - BITS and the default update period (1200), shared with the counter;
  - MIN_PERIOD;
  - the loader state enum (IDLE/SHIFT/CHECK/LOAD);
  - the FRAME_LEN derivation.
- Sub-module sync_edge: 2-flop synchroniser, delay flop, rise/fall pulse outputs, async active-low reset with a parameterised reset level. Instantiated once per pin (3×).

Test Plan:
- Reset release with pins idle -> period = 1200, period_load = 0, busy = 0, err = 0, and they stay so for 100 cycles.
- 12-bit frame 0x258 at sclk = clk/8 -> single period_load pulse with period = 600 in that cycle; busy falls; err never asserted.
- 11-bit frame 0x0FF, then a 13-bit frame -> err pulse per frame, no period_load, period still 1200.
- Frame value 8 (< MIN_PERIOD) -> err pulse, period unchanged; next valid frame 0x010 -> period = 16 with load.
- reset_n asserted after 6 of 12 bits -> outputs return to reset values immediately; the remaining bits and latch rise produce no load and no err.
- With PERIOD_CONFIG_PARITY_EN:
  - 0x258 plus parity bit 0 -> accepted;
  - 0x258 plus parity bit 1 -> err, no load;
  - a back-to-back valid frame 0x4B0 after a 4-cycle gap -> period = 1200 with load.
